// File: rtl/simple_cpu_controller.sv
// -----------------------------------------------------------------------------
// simple_cpu_controller
//
// Control unit for the SimpleCPU. Owns the program counter (PC) and the
// instruction register (IR). Fetches 16-bit instructions from instruction
// memory, decodes them and sequences LOAD / STORE / ADD / SUB / LDC / JMPZ /
// HALT by driving every datapath and data-memory control input. It consumes
// the datapath's RF_Rp_zero flag to resolve conditional jumps.
//
// Ports
//   clk            in   1     system clock, rising edge
//   rst            in   1     asynchronous, active-low reset
//   I_addr         out  PC_W  instruction memory address (= PC)
//   I_rd           out  1     instruction memory read strobe
//   I_data         in   16    instruction word, combinational read
//   D_addr         out  DA_W  data memory address (= IR[7:0])
//   D_rd / D_wr    out  1     data memory read / write strobes
//   RF_W_data      out  8     load-constant value (= IR[7:0])
//   RF_s1, RF_s0   out  1     RF write mux: 00 ALU, 01 DM_Din, 10 RF_W_data
//   RF_W_addr/_wr  out  4/1   RF write address / enable
//   RF_Rp_addr/_rd out  4/1   RF read port P address / enable
//   RF_Rq_addr/_rd out  4/1   RF read port Q address / enable
//   alu_s1, alu_s0 out  1     ALU op: 00 pass A, 01 A+B, 10 A-B
//   RF_Rp_zero     in   1     datapath flag: port P read data is zero
//   halted         out  1     high while in HALT
//
// Timing: FETCH, DECODE, EXECUTE -> 3 cycles per instruction; a taken JMPZ
// adds a JTAKE cycle (4); a NOP returns to FETCH straight from DECODE (2).
// -----------------------------------------------------------------------------
module simple_cpu_controller #(
   parameter int PC_W = 16,
   parameter int DA_W = 8
) (
   input  logic            clk,
   input  logic            rst,
   output logic [PC_W-1:0] I_addr,
   output logic            I_rd,
   input  logic [15:0]     I_data,
   output logic [DA_W-1:0] D_addr,
   output logic            D_rd,
   output logic            D_wr,
   output logic [7:0]      RF_W_data,
   output logic            RF_s1,
   output logic            RF_s0,
   output logic [3:0]      RF_W_addr,
   output logic            RF_W_wr,
   output logic [3:0]      RF_Rp_addr,
   output logic            RF_Rp_rd,
   output logic [3:0]      RF_Rq_addr,
   output logic            RF_Rq_rd,
   output logic            alu_s1,
   output logic            alu_s0,
   input  logic            RF_Rp_zero,
   output logic            halted
);

   typedef enum logic [3:0] {
      S_INIT,
      S_FETCH,
      S_DECODE,
      S_LOAD,
      S_STORE,
      S_ADD,
      S_LDC,
      S_SUB,
      S_JMPZ,
      S_JTAKE,
      S_HALT
   } state_e;

   localparam logic [3:0] OP_LOAD  = 4'b0000;
   localparam logic [3:0] OP_STORE = 4'b0001;
   localparam logic [3:0] OP_ADD   = 4'b0010;
   localparam logic [3:0] OP_LDC   = 4'b0011;
   localparam logic [3:0] OP_SUB   = 4'b0100;
   localparam logic [3:0] OP_JMPZ  = 4'b0101;
   localparam logic [3:0] OP_HALT  = 4'b1111;

   state_e          state_q, state_d;
   logic [PC_W-1:0] pc_q, pc_d;
   logic [15:0]     ir_q, ir_d;

   // Instruction fields, always taken from the latched IR.
   logic [3:0]      opcode;
   logic [3:0]      f_a, f_b, f_c;
   logic [7:0]      f_d;
   logic [PC_W-1:0] jump_target;

   assign opcode = ir_q[15:12];
   assign f_a    = ir_q[11:8];
   assign f_b    = ir_q[7:4];
   assign f_c    = ir_q[3:0];
   assign f_d    = ir_q[7:0];

   // PC already points past the JMPZ when JTAKE executes, so the -1 makes the
   // offset relative to the JMPZ itself (d = 0 re-executes the jump).
   assign jump_target = pc_q + {{(PC_W-8){f_d[7]}}, f_d} - PC_W'(1);

   // --------------------------------------------------------------------------
   // State register
   // --------------------------------------------------------------------------
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values computed by the combinational processes.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_INIT;
         pc_q    <= '0;
         ir_q    <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         ir_q    <= ir_d;
      end
   end

   // --------------------------------------------------------------------------
   // Next-state logic (state, PC, IR)
   // --------------------------------------------------------------------------
   // NOTE: every signal written here gets a hold/default value first, so no
   // path through the case statement can infer a latch.
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      ir_d    = ir_q;
      unique case (state_q)
         S_INIT: begin
            pc_d    = '0;
            state_d = S_FETCH;
         end
         S_FETCH: begin
            ir_d    = I_data;
            pc_d    = pc_q + PC_W'(1);
            state_d = S_DECODE;
         end
         S_DECODE: begin
            case (opcode)
               OP_LOAD:  state_d = S_LOAD;
               OP_STORE: state_d = S_STORE;
               OP_ADD:   state_d = S_ADD;
               OP_LDC:   state_d = S_LDC;
               OP_SUB:   state_d = S_SUB;
               OP_JMPZ:  state_d = S_JMPZ;
               OP_HALT:  state_d = S_HALT;
               default:  state_d = S_FETCH;  // unassigned opcodes act as NOP
            endcase
         end
         S_LOAD, S_STORE, S_ADD, S_LDC, S_SUB: begin
            state_d = S_FETCH;
         end
         S_JMPZ: begin
            // Rp is being read from RF[a] this cycle; its zero flag decides.
            state_d = RF_Rp_zero ? S_JTAKE : S_FETCH;
         end
         S_JTAKE: begin
            pc_d    = jump_target;
            state_d = S_FETCH;
         end
         S_HALT: begin
            state_d = S_HALT;
         end
         default: begin
            state_d = S_INIT;
         end
      endcase
   end

   // --------------------------------------------------------------------------
   // Moore outputs, decoded from state and IR
   // --------------------------------------------------------------------------
   always_comb begin
      // I_addr mirrors the PC; it only matters while I_rd is high.
      I_addr     = pc_q;
      I_rd       = 1'b0;
      D_addr     = '0;
      D_rd       = 1'b0;
      D_wr       = 1'b0;
      RF_W_data  = '0;
      RF_s1      = 1'b0;
      RF_s0      = 1'b0;
      RF_W_addr  = '0;
      RF_W_wr    = 1'b0;
      RF_Rp_addr = '0;
      RF_Rp_rd   = 1'b0;
      RF_Rq_addr = '0;
      RF_Rq_rd   = 1'b0;
      alu_s1     = 1'b0;
      alu_s0     = 1'b0;
      halted     = 1'b0;
      unique case (state_q)
         S_FETCH: begin
            I_rd = 1'b1;
         end
         S_LOAD: begin
            D_rd      = 1'b1;
            D_addr    = ir_q[DA_W-1:0];
            RF_s0     = 1'b1;
            RF_W_addr = f_a;
            RF_W_wr   = 1'b1;
         end
         S_STORE: begin
            D_wr       = 1'b1;
            D_addr     = ir_q[DA_W-1:0];
            RF_Rp_addr = f_a;
            RF_Rp_rd   = 1'b1;
         end
         S_ADD, S_SUB: begin
            RF_Rp_addr = f_b;
            RF_Rp_rd   = 1'b1;
            RF_Rq_addr = f_c;
            RF_Rq_rd   = 1'b1;
            alu_s1     = (state_q == S_SUB);
            alu_s0     = (state_q == S_ADD);
            RF_W_addr  = f_a;
            RF_W_wr    = 1'b1;
         end
         S_LDC: begin
            RF_W_data = f_d;
            RF_s1     = 1'b1;
            RF_W_addr = f_a;
            RF_W_wr   = 1'b1;
         end
         S_JMPZ: begin
            RF_Rp_addr = f_a;
            RF_Rp_rd   = 1'b1;
         end
         S_HALT: begin
            halted = 1'b1;
         end
         default: begin
            // INIT, DECODE and JTAKE drive no strobes.
         end
      endcase
   end

endmodule
